// File: rtl/gc_rect_nd_sequencer.sv
// Register-programmed rectangular N-dimensional loop sequencer for the TCPA global controller.
// Walks lower..upper with per-dimension strides and presents one iteration vector every II cycles.
module gc_rect_nd_sequencer #(
  parameter int DIMENSION                = 3,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int II_WIDTH                 = 8,
  parameter int ADDR_WIDTH               = 6
) (
  input  logic                                          gc_clk,
  input  logic                                          reset,
  input  logic                                          conf_en,
  input  logic [ADDR_WIDTH-1:0]                         conf_addr,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0]           conf_data,
  output logic                                          conf_ack,
  input  logic                                          start,
  input  logic                                          stop,
  output logic                                          global_en,
  output logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] x_bus,
  output logic [2*DIMENSION-1:0]                        ic,
  output logic                                          iter_valid,
  output logic                                          reinitialize,
  output logic                                          gc_done,
  output logic [31:0]                                   iter_count
);
  localparam int W = ITERATION_VARIABLE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] II_ADDR   = ADDR_WIDTH'(3 * DIMENSION);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(3 * DIMENSION + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]         lower_q    [DIMENSION];
  logic [W-1:0]         lower_d    [DIMENSION];
  logic [W-1:0]         upper_q    [DIMENSION];
  logic [W-1:0]         upper_d    [DIMENSION];
  logic [W-1:0]         stride_q   [DIMENSION];
  logic [W-1:0]         stride_d   [DIMENSION];
  logic [W-1:0]         x_q        [DIMENSION];
  logic [W-1:0]         x_d        [DIMENSION];
  logic [W-1:0]         stride_eff [DIMENSION];
  logic [II_WIDTH-1:0]  ii_q, ii_d, ii_cnt_q, ii_cnt_d, ii_last;
  logic                 restart_q, restart_d;
  logic [31:0]          iter_count_q, iter_count_d;
  logic                 conf_ack_q, conf_ack_d;
  logic                 iter_valid_q, iter_valid_d;
  logic                 reinit_q, reinit_d;
  logic [DIMENSION-1:0] last;
  logic                 carry;

  // "last" is evaluated one bit wider so x+stride never wraps back below upper.
  always_comb begin
    ii_last = (ii_q == '0) ? '0 : ii_q - II_WIDTH'(1);
    last    = '0;
    for (int d = 0; d < DIMENSION; d++) begin
      stride_eff[d] = (stride_q[d] == '0) ? W'(1) : stride_q[d];
      last[d] = (lower_q[d] > upper_q[d]) ||
                (({1'b0, x_q[d]} + {1'b0, stride_eff[d]}) > {1'b0, upper_q[d]});
    end
  end

  always_comb begin
    state_d      = state_q;
    lower_d      = lower_q;
    upper_d      = upper_q;
    stride_d     = stride_q;
    x_d          = x_q;
    ii_d         = ii_q;
    restart_d    = restart_q;
    ii_cnt_d     = ii_cnt_q;
    iter_count_d = iter_count_q;
    conf_ack_d   = 1'b0;
    iter_valid_d = 1'b0;
    reinit_d     = 1'b0;
    carry        = 1'b0;

    if (conf_en && (state_q == IDLE || state_q == DONE)) begin
      if (conf_addr == II_ADDR) begin
        ii_d       = conf_data[II_WIDTH-1:0];
        conf_ack_d = 1'b1;
      end else if (conf_addr == CTRL_ADDR) begin
        restart_d  = conf_data[0];
        conf_ack_d = 1'b1;
      end
      for (int d = 0; d < DIMENSION; d++) begin
        if (conf_addr == ADDR_WIDTH'(3 * d)) begin
          lower_d[d] = conf_data;
          conf_ack_d = 1'b1;
        end
        if (conf_addr == ADDR_WIDTH'(3 * d + 1)) begin
          upper_d[d] = conf_data;
          conf_ack_d = 1'b1;
        end
        if (conf_addr == ADDR_WIDTH'(3 * d + 2)) begin
          stride_d[d] = conf_data;
          conf_ack_d  = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_d      = RUN;
          x_d          = lower_q;
          ii_cnt_d     = '0;
          iter_count_d = 32'd1;
          iter_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (ii_cnt_q != ii_last) begin
          ii_cnt_d = ii_cnt_q + II_WIDTH'(1);
        end else begin
          ii_cnt_d = '0;
          carry    = 1'b1;
          // Odometer: first non-last dimension absorbs the carry.
          for (int d = 0; d < DIMENSION; d++) begin
            if (carry) begin
              if (last[d]) begin
                x_d[d] = lower_q[d];
              end else begin
                x_d[d] = x_q[d] + stride_eff[d];
                carry  = 1'b0;
              end
            end
          end
          if (!carry || restart_q) begin
            iter_valid_d = 1'b1;
            reinit_d     = carry;
            iter_count_d = iter_count_q + 32'd1;
          end else begin
            state_d = DONE;
            x_d     = x_q;
          end
        end
      end
      PAUSE: begin
        if (start && !stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gc_clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int d = 0; d < DIMENSION; d++) begin
        lower_q[d]  <= '0;
        upper_q[d]  <= '0;
        stride_q[d] <= '0;
        x_q[d]      <= '0;
      end
      ii_q         <= '0;
      restart_q    <= 1'b0;
      ii_cnt_q     <= '0;
      iter_count_q <= '0;
      conf_ack_q   <= 1'b0;
      iter_valid_q <= 1'b0;
      reinit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lower_q      <= lower_d;
      upper_q      <= upper_d;
      stride_q     <= stride_d;
      x_q          <= x_d;
      ii_q         <= ii_d;
      restart_q    <= restart_d;
      ii_cnt_q     <= ii_cnt_d;
      iter_count_q <= iter_count_d;
      conf_ack_q   <= conf_ack_d;
      iter_valid_q <= iter_valid_d;
      reinit_q     <= reinit_d;
    end
  end

  always_comb begin
    x_bus = '0;
    ic    = '0;
    for (int d = 0; d < DIMENSION; d++) begin
      x_bus[d*W +: W] = x_q[d];
      if (state_q != IDLE) begin
        ic[2*d]   = (x_q[d] == lower_q[d]);
        ic[2*d+1] = last[d];
      end
    end
  end

  assign conf_ack     = conf_ack_q;
  assign iter_valid   = iter_valid_q;
  assign reinitialize = reinit_q;
  assign iter_count   = iter_count_q;
  assign gc_done      = (state_q == DONE);
  assign global_en    = (state_q == RUN);

endmodule

// File: tb/tb_gc_rect_nd_sequencer.sv
// Bench for gc_rect_nd_sequencer: directed and random 2-D runs compared against an
// enumerated list of iteration vectors built from the bounds/strides.
module tb_gc_rect_nd_sequencer;
  localparam int D   = 2;
  localparam int W   = 16;
  localparam int IIW = 8;
  localparam int AW  = 6;

  logic           gc_clk = 1'b0;
  logic           reset, conf_en, start, stop;
  logic [AW-1:0]  conf_addr;
  logic [W-1:0]   conf_data;
  logic           conf_ack, global_en, iter_valid, reinitialize, gc_done;
  logic [D*W-1:0] x_bus;
  logic [2*D-1:0] ic;
  logic [31:0]    iter_count;

  int checks = 0;
  int errors = 0;

  int unsigned    m_lo [D];
  int unsigned    m_hi [D];
  int unsigned    m_st [D];
  int             m_ii_eff;
  int             m_n;
  bit             m_rm;
  logic [D*W-1:0] m_seq [$];
  logic [2*D-1:0] m_icq [$];

  always #5 gc_clk = ~gc_clk;

  gc_rect_nd_sequencer #(
    .DIMENSION(D), .ITERATION_VARIABLE_WIDTH(W), .II_WIDTH(IIW), .ADDR_WIDTH(AW)
  ) dut (
    .gc_clk(gc_clk), .reset(reset), .conf_en(conf_en), .conf_addr(conf_addr),
    .conf_data(conf_data), .conf_ack(conf_ack), .start(start), .stop(stop),
    .global_en(global_en), .x_bus(x_bus), .ic(ic), .iter_valid(iter_valid),
    .reinitialize(reinitialize), .gc_done(gc_done), .iter_count(iter_count)
  );

  task automatic tick();
    @(posedge gc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enumerate each dimension's value list, then the product with dim 0 fastest.
  task automatic build_model();
    int unsigned vl [D][64];
    int          vn [D];
    longint      st;
    m_seq.delete();
    m_icq.delete();
    for (int d = 0; d < D; d++) begin
      vn[d] = 0;
      st = (m_st[d] == 0) ? 64'sd1 : longint'(m_st[d]);
      if (m_lo[d] > m_hi[d]) begin
        vl[d][0] = m_lo[d];
        vn[d]    = 1;
      end else begin
        for (longint v = longint'(m_lo[d]); v <= longint'(m_hi[d]) && vn[d] < 64; v += st) begin
          vl[d][vn[d]] = 32'(v);
          vn[d]++;
        end
      end
    end
    for (int i1 = 0; i1 < vn[1]; i1++)
      for (int i0 = 0; i0 < vn[0]; i0++) begin
        m_seq.push_back({16'(vl[1][i1]), 16'(vl[0][i0])});
        m_icq.push_back({i1 == vn[1] - 1, vl[1][i1] == m_lo[1],
                         i0 == vn[0] - 1, vl[0][i0] == m_lo[0]});
      end
    m_n = vn[0] * vn[1];
  endtask

  task automatic cfg_write(input int addr, input int data, input bit exp_ack, input string tag);
    conf_en   = 1'b1;
    conf_addr = AW'(addr);
    conf_data = W'(data);
    tick();
    conf_en = 1'b0;
    chk({tag, ".ack"}, conf_ack, exp_ack);
  endtask

  task automatic configure(input int lo0, input int hi0, input int st0,
                           input int lo1, input int hi1, input int st1,
                           input int ii_data, input int rm, input string tag);
    m_lo[0] = lo0; m_hi[0] = hi0; m_st[0] = st0;
    m_lo[1] = lo1; m_hi[1] = hi1; m_st[1] = st1;
    m_ii_eff = ((ii_data & 255) == 0) ? 1 : (ii_data & 255);
    m_rm     = rm[0];
    cfg_write(0, lo0, 1'b1, {tag, ".lo0"});
    cfg_write(1, hi0, 1'b1, {tag, ".hi0"});
    cfg_write(2, st0, 1'b1, {tag, ".st0"});
    cfg_write(3, lo1, 1'b1, {tag, ".lo1"});
    cfg_write(4, hi1, 1'b1, {tag, ".hi1"});
    cfg_write(5, st1, 1'b1, {tag, ".st1"});
    cfg_write(6, ii_data, 1'b1, {tag, ".ii"});
    cfg_write(7, rm, 1'b1, {tag, ".ctrl"});
    build_model();
  endtask

  // c = RUN cycles elapsed since the first vector was presented.
  task automatic check_cycle(input int c, input string tag);
    int k, idx;
    bit boundary;
    k        = c / m_ii_eff;
    idx      = m_rm ? (k % m_n) : k;
    boundary = (c % m_ii_eff) == 0;
    chk({tag, ".iter_valid"}, iter_valid, boundary);
    chk({tag, ".reinit"}, reinitialize, m_rm && boundary && k > 0 && (k % m_n) == 0);
    chk({tag, ".x"}, x_bus, m_seq[idx]);
    chk({tag, ".count"}, iter_count, k + 1);
    chk({tag, ".done"}, gc_done, 1'b0);
    chk({tag, ".gen"}, global_en, 1'b1);
    chk({tag, ".ic"}, ic, m_icq[idx]);
  endtask

  task automatic check_done(input string tag);
    chk({tag, ".end_done"}, gc_done, 1'b1);
    chk({tag, ".end_gen"}, global_en, 1'b0);
    chk({tag, ".end_valid"}, iter_valid, 1'b0);
    chk({tag, ".end_reinit"}, reinitialize, 1'b0);
    chk({tag, ".end_x"}, x_bus, m_seq[m_n-1]);
    chk({tag, ".end_count"}, iter_count, m_n);
    chk({tag, ".end_ic"}, ic, m_icq[m_n-1]);
  endtask

  task automatic run_oneshot(input string tag, input int poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < m_n * m_ii_eff; c++) begin
      check_cycle(c, tag);
      if (c == poke) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_done(tag);
  endtask

  initial begin
    reset = 1'b1; conf_en = 1'b0; conf_addr = '0; conf_data = '0; start = 1'b0; stop = 1'b0;
    tick();
    tick();
    chk("rst.x", x_bus, 0);
    chk("rst.ic", ic, 0);
    chk("rst.count", iter_count, 0);
    chk("rst.ack", conf_ack, 0);
    chk("rst.valid", iter_valid, 0);
    chk("rst.reinit", reinitialize, 0);
    chk("rst.done", gc_done, 0);
    chk("rst.gen", global_en, 0);
    reset = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("idle_startstop.gen", global_en, 0);
    chk("idle_startstop.valid", iter_valid, 0);
    chk("idle.ic", ic, 0);

    configure(0, 2, 1, 0, 1, 1, 1, 0, "t1");
    run_oneshot("t1", -1);
    chk("t1.final_x", x_bus, 32'h0001_0002);
    chk("t1.final_count", iter_count, 6);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("done_stop.done", gc_done, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("done_startstop.done", gc_done, 1);
    chk("done_startstop.valid", iter_valid, 0);
    cfg_write(8, 5, 1'b0, "unmapped8");
    cfg_write(63, 5, 1'b0, "unmapped63");

    configure(0, 2, 1, 0, 1, 1, 3, 0, "t2");
    run_oneshot("t2", 4);
    configure(1, 5, 2, 0, 1, 0, 2, 0, "t3");
    run_oneshot("t3", -1);
    configure(0, 'hFFFF, 'h8000, 3, 2, 5, 'h0301, 0, "t4");
    run_oneshot("t4", -1);
    chk("t4.n", m_n, 2);

    for (int r = 0; r < 5; r++) begin
      configure(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 0, "rnd");
      run_oneshot("rnd", int'($urandom_range(0, 8)));
    end

    configure(0, 2, 1, 0, 1, 1, 4, 0, "pz");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      check_cycle(c, "pz_pre");
      if (c == 4) begin
        conf_en = 1'b1; conf_addr = '0; conf_data = 16'd9;
      end
      if (c == 5) chk("run_write.ack", conf_ack, 0);
      if (c < 9) begin
        tick();
        conf_en = 1'b0;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int p = 0; p < 10; p++) begin
      chk("pz.gen", global_en, 0);
      chk("pz.x", x_bus, m_seq[2]);
      chk("pz.count", iter_count, 3);
      chk("pz.valid", iter_valid, 0);
      chk("pz.ic", ic, m_icq[2]);
      if (p == 4) chk("pause_write.ack", conf_ack, 0);
      if (p == 3) begin
        conf_en = 1'b1; conf_addr = 6'd1; conf_data = 16'd0;
      end
      tick();
      conf_en = 1'b0;
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("pz_startstop.gen", global_en, 0);
    chk("pz_startstop.x", x_bus, m_seq[2]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 9; c < m_n * m_ii_eff; c++) begin
      check_cycle(c, "pz_post");
      tick();
    end
    check_done("pz");

    configure(0, 1, 1, 0, 1, 1, 2, 1, "rs");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3 * m_n * m_ii_eff; c++) begin
      check_cycle(c, "rs");
      if (c == 8) chk("rs.wrap_count", iter_count, 5);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.x", x_bus, 0);
    chk("midrst.ic", ic, 0);
    chk("midrst.count", iter_count, 0);
    chk("midrst.valid", iter_valid, 0);
    chk("midrst.reinit", reinitialize, 0);
    chk("midrst.done", gc_done, 0);
    chk("midrst.gen", global_en, 0);
    chk("midrst.ack", conf_ack, 0);

    for (int d = 0; d < D; d++) begin
      m_lo[d] = 0; m_hi[d] = 0; m_st[d] = 0;
    end
    m_ii_eff = 1;
    m_rm     = 1'b0;
    build_model();
    run_oneshot("cleared", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gc_rect_nd_sequencer.md
Name: gc_rect_nd_sequencer

Overview:
- Parametrised next-generation rectangular global controller that walks an N-dimensional rectangular iteration space on a single clock.
- Supports per-dimension lower/upper bounds and strides, a programmable iteration interval (II), pause/resume, and one-shot or auto-restart modes.
- Emits the current iteration vector, first/last-of-dimension ic flags, and iteration/done strobes to the TCPA array and its peripheries (AGs).
- Replaces the separate comparator-matrix, stride-selector, initializer and reinitializer path with a single register-programmed sequencer.

Parameters:
DIMENSION, 3, number of loop dimensions; dim 0 is innermost.
ITERATION_VARIABLE_WIDTH, 16, width of each iteration variable, bound and stride (unsigned).
II_WIDTH, 8, width of the iteration-interval register.
ADDR_WIDTH, 6, configuration address width; must satisfy 2^ADDR_WIDTH >= 3*DIMENSION+2.

Ports:
gc_clk  in  1  single clock for configuration and run.
reset  in  1  synchronous, active-high.
conf_en  in  1  configuration write strobe.
conf_addr  in  ADDR_WIDTH  register address.
conf_data  in  ITERATION_VARIABLE_WIDTH  write data.
conf_ack  out  1  one-cycle pulse, write accepted.
start  in  1  start or resume.
stop  in  1  pause.
global_en  out  1  high while in RUN.
x_bus  out  DIMENSION*ITERATION_VARIABLE_WIDTH  current iteration; dim d at bits [d*W +: W].
ic  out  2*DIMENSION  bit 2d = x[d]==lower[d]; bit 2d+1 = x[d] is last value of dim d.
iter_valid  out  1  pulse on the first cycle a new iteration vector is presented.
reinitialize  out  1  pulse when an auto-restart wraps the whole space.
gc_done  out  1  level, high in DONE.
iter_count  out  32  iterations issued since start from IDLE/DONE; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, any state, including mid-run):
  - state=IDLE; all config registers=0.
  - x_bus, ic, iter_count, conf_ack, iter_valid, reinitialize, gc_done, global_en = 0.
- Register map:
  - addr 3d+0 = lower[d]; 3d+1 = upper[d]; 3d+2 = stride[d].
  - addr 3*DIMENSION = II (low II_WIDTH bits).
  - addr 3*DIMENSION+1 = ctrl; bit0 = restart_mode.
- Configuration writes:
  - Accepted only in IDLE or DONE: register updates on the conf_en edge; conf_ack pulses the following cycle.
  - Writes in RUN/PAUSE, or to an unmapped address, are dropped and give no conf_ack.
- Effective values:
  - stride 0 is treated as 1; II 0 is treated as 1.
  - "last" for dim d means x[d] + stride[d] > upper[d], computed at W+1 bits (no overflow wrap).
  - lower[d] > upper[d] makes the dimension single-valued (x[d]=lower[d], always last).
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE/DONE --start--> RUN: next cycle x=all lowers, iter_valid=1, iter_count=1, ii_cnt=0, gc_done=0.
  - RUN: ii_cnt increments each cycle. When ii_cnt==II-1: ii_cnt=0 and the space advances; iter_valid pulses with the new x; iter_count+1.
  - Advance: odometer from dim 0. A non-last dim adds its stride and stops the carry; a last dim resets to lower and carries to the next.
  - Carry out of dim DIMENSION-1 with restart_mode=1: all dims at lower, reinitialize and iter_valid pulse together, stay RUN.
  - Carry out of dim DIMENSION-1 with restart_mode=0: go to DONE; x holds the final vector; gc_done=1; no iter_valid.
  - RUN --stop--> PAUSE: x, ii_cnt and iter_count frozen; global_en=0.
  - PAUSE --start--> RUN: resumes the same II window, with no iter_valid until the next advance.
  - start and stop asserted together: stop wins (RUN→PAUSE; PAUSE stays; IDLE/DONE stay).
  - start while in RUN is ignored. stop in IDLE/DONE is ignored.
- Output timing:
  - ic is combinational from registered x and the config; valid whenever state≠IDLE, 0 in IDLE.
  - global_en = (state==RUN), registered.
- Iteration interval: total RUN cycles for a one-shot run = N_iterations*II; DONE is entered the cycle after the last window ends.

Test Plan:
- DIMENSION=2, lower=(0,0), upper=(2,1), stride=(1,1), II=1, one-shot, start → x sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then gc_done=1 after 6 iter_valid pulses, iter_count=6, x held at (2,1).
- Same space with II=3 → iter_valid every 3rd cycle; DONE reached 18 cycles after the first x presentation; ic[1] (last of dim0) high exactly when x0==2.
- stride0=2, upper0=5, lower0=1 → dim0 values 1,3,5. upper0=0xFFFF, stride0=0x8000, lower0=0 → values 0,0x8000 then wrap (no overflow). stride0=0 → behaves as 1.
- restart_mode=1, 2x2 space → after the 4th iteration x returns to lowers with reinitialize+iter_valid in the same cycle; gc_done stays 0; iter_count continues 5,6,...
- Pause at iteration 3 with II=4 mid-window (stop) for 10 cycles, then start → x unchanged during pause; remaining window cycles completed after resume; start+stop in the same cycle keeps PAUSE.
- Config write during RUN → no conf_ack, register unchanged. Synchronous reset asserted mid-RUN → next cycle all outputs 0, state IDLE, bounds cleared.
